// File: rtl/maxpool_pkg.sv
// Shared definitions for the 2x2 / stride-2 max-pool controller.
// Build option: MAXPOOL_CTRL_SIGNED_EN selects two's-complement signed pixel
// comparison; when undefined, pixels compare as unsigned values.
package maxpool_pkg;

   localparam int DATAWIDTH = 64;
   localparam int MAX_W     = 256;
   localparam int DIM_BITS  = $clog2(MAX_W) + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } state_e;

   // Larger of two pixels; on a tie either operand is the same value.
   function automatic logic [DATAWIDTH-1:0] max2(input logic [DATAWIDTH-1:0] a,
                                                  input logic [DATAWIDTH-1:0] b);
`ifdef MAXPOOL_CTRL_SIGNED_EN
      return ($signed(a) >= $signed(b)) ? a : b;
`else
      return (a >= b) ? a : b;
`endif
   endfunction

endpackage

// File: rtl/maxpool_line_buf.sv
// Half-row line buffer holding horizontal pair maxima from the even row.
// One synchronous write port, one combinational read port. Storage is not
// reset: every entry read on an odd row was written earlier on the even row.
module maxpool_line_buf
#(
   parameter int DEPTH = maxpool_pkg::MAX_W / 2,
   parameter int WIDTH = maxpool_pkg::DATAWIDTH,
   parameter int AW    = $clog2(DEPTH)
)
(
   input  logic             CLK,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Store one pair maximum per even-row pixel pair.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/maxpool_ctrl.sv
// Streaming 2x2 / stride-2 max-pool controller for one feature-map plane.
// Pixels arrive in raster order; even rows fold pixel pairs into the line
// buffer, odd rows fold pixel pairs with the stored pair and emit a result.
// Build option: MAXPOOL_CTRL_SIGNED_EN (signed compare, see maxpool_pkg).
//
// state | meaning
// IDLE  | waiting for start; validates config, pulses cfg_err on reject
// RUN   | accepting pixels, producing pooled outputs
// FLUSH | all pixels taken; waiting for the last pooled pixel to drain
module maxpool_ctrl
#(
   parameter int DATAWIDTH = maxpool_pkg::DATAWIDTH,
   parameter int MAX_W     = maxpool_pkg::MAX_W,
   parameter int DIM_BITS  = maxpool_pkg::DIM_BITS
)
(
   input  logic                 CLK,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [DIM_BITS-1:0]  cfg_width,
   input  logic [DIM_BITS-1:0]  cfg_height,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] out_data,
   output logic                 busy,
   output logic                 done,
   output logic                 cfg_err
);

   import maxpool_pkg::*;

   localparam int LB_DEPTH = MAX_W / 2;
   localparam int LB_AW    = $clog2(LB_DEPTH);

   state_e                state_q, state_d;
   logic [DIM_BITS-1:0]   width_q, width_d;
   logic [DIM_BITS-1:0]   height_q, height_d;
   logic [DIM_BITS-1:0]   col_q, col_d;
   logic [DIM_BITS-1:0]   row_q, row_d;
   logic [DATAWIDTH-1:0]  h_reg_q, h_reg_d;
   logic [DATAWIDTH-1:0]  out_data_q, out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  done_q, done_d;
   logic                  cfg_err_q, cfg_err_d;

   logic                  cfg_ok;
   logic                  accept;
   logic                  col_last;
   logic                  row_last;
   logic                  frame_last;
   logic                  out_free;
   logic                  lb_wr_en;
   logic [LB_AW-1:0]      lb_addr;
   logic [DATAWIDTH-1:0]  lb_rd_data;
   logic [DATAWIDTH-1:0]  pair_max;
   logic [DATAWIDTH-1:0]  win_max;
   logic                  load_out;

   // Frame dimensions must be nonzero, even, and the width must fit the buffer.
   assign cfg_ok = (cfg_width != '0) && (cfg_height != '0) &&
                   !cfg_width[0] && !cfg_height[0] &&
                   (cfg_width <= DIM_BITS'(MAX_W));

   // Output register can take a new result when empty or draining this cycle.
   assign out_free   = !out_valid_q || out_ready;
   assign accept     = in_valid && in_ready;
   assign col_last   = (col_q == width_q - DIM_BITS'(1));
   assign row_last   = (row_q == height_q - DIM_BITS'(1));
   assign frame_last = accept && col_last && row_last;

   // Column pair index addresses the half-row buffer.
   assign lb_addr  = col_q[LB_AW:1];
   assign pair_max = max2(h_reg_q, in_data);
   assign win_max  = max2(lb_rd_data, pair_max);
   assign lb_wr_en = accept && !row_q[0] && col_q[0];
   assign load_out = accept && row_q[0] && col_q[0];

   maxpool_line_buf #(
      .DEPTH (LB_DEPTH),
      .WIDTH (DATAWIDTH),
      .AW    (LB_AW)
   ) u_line_buf (
      .CLK     (CLK),
      .wr_en   (lb_wr_en),
      .wr_addr (lb_addr),
      .wr_data (pair_max),
      .rd_addr (lb_addr),
      .rd_data (lb_rd_data)
   );

   // State register.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; start while busy is simply not looked at.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start && cfg_ok) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (frame_last) begin
               state_d = FLUSH;
            end
         end
         FLUSH: begin
            if (out_free) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      in_ready  = (state_q == RUN) && out_free;
      busy      = (state_q != IDLE);
      out_valid = out_valid_q;
      out_data  = out_data_q;
      done      = done_q;
      cfg_err   = cfg_err_q;
   end

   // Datapath next values: config latch, counters, pair register, output register.
   always_comb begin
      width_d     = width_q;
      height_d    = height_q;
      col_d       = col_q;
      row_d       = row_q;
      h_reg_d     = h_reg_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      done_d      = 1'b0;
      cfg_err_d   = 1'b0;

      if ((state_q == IDLE) && start) begin
         if (cfg_ok) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            col_d    = '0;
            row_d    = '0;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      if (accept) begin
         if (col_last) begin
            col_d = '0;
            row_d = row_q + DIM_BITS'(1);
         end else begin
            col_d = col_q + DIM_BITS'(1);
         end
         if (!col_q[0]) begin
            h_reg_d = in_data;
         end
      end

      // A result loaded in the same cycle as a drain keeps out_valid high.
      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
      if (load_out) begin
         out_valid_d = 1'b1;
         out_data_d  = win_max;
      end

      if ((state_q == FLUSH) && out_free) begin
         done_d = 1'b1;
      end
   end

   // Datapath registers; reset drops any pending output.
   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         width_q     <= '0;
         height_q    <= '0;
         col_q       <= '0;
         row_q       <= '0;
         h_reg_q     <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         done_q      <= 1'b0;
         cfg_err_q   <= 1'b0;
      end else begin
         width_q     <= width_d;
         height_q    <= height_d;
         col_q       <= col_d;
         row_q       <= row_d;
         h_reg_q     <= h_reg_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         done_q      <= done_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl: directed frames from the test plan
// plus randomized frames compared against a window-maximum reference model.
module tb_maxpool_ctrl;

   localparam int DW    = 64;
   localparam int MAXW  = 256;
   localparam int DIMB  = 9;

   logic            CLK;
   logic            rst_n;
   logic            start;
   logic [DIMB-1:0] cfg_width;
   logic [DIMB-1:0] cfg_height;
   logic            in_valid;
   logic            in_ready;
   logic [DW-1:0]   in_data;
   logic            out_valid;
   logic            out_ready;
   logic [DW-1:0]   out_data;
   logic            busy;
   logic            done;
   logic            cfg_err;

   int errors = 0;
   int checks = 0;

   logic [DW-1:0] pix_q[$];
   logic [DW-1:0] last_out;

   maxpool_ctrl dut (
      .CLK        (CLK),
      .rst_n      (rst_n),
      .start      (start),
      .cfg_width  (cfg_width),
      .cfg_height (cfg_height),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .busy       (busy),
      .done       (done),
      .cfg_err    (cfg_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [DW-1:0] ref_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef MAXPOOL_CTRL_SIGNED_EN
      return ($signed(a) > $signed(b)) ? a : b;
`else
      return (a > b) ? a : b;
`endif
   endfunction

   function automatic logic [DW-1:0] rand_pix();
      logic [DW-1:0] v;
      v = {$urandom, $urandom};
      if ($urandom_range(3) == 0) v = DW'($urandom_range(7));
      return v;
   endfunction

   // Runs one frame from pix_q (raster order) and checks every pooled output,
   // the stall behaviour and done timing.
   task automatic run_frame(input int w, input int h, input int vpct, input int rpct,
                            input int stall_n, input bit mid_start, input bit chained,
                            input string name);
      int n, idx, got, cyc, last_hs, stall_left, budget;
      bit done_seen, stall_used, prev_stalled;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] exp_q[$];
      logic [DW-1:0] m;
      n = w * h;
      for (int r = 0; r < h / 2; r++) begin
         for (int c = 0; c < w / 2; c++) begin
            m = ref_max(ref_max(pix_q[2*r*w + 2*c], pix_q[2*r*w + 2*c + 1]),
                        ref_max(pix_q[(2*r+1)*w + 2*c], pix_q[(2*r+1)*w + 2*c + 1]));
            exp_q.push_back(m);
         end
      end
      if (!chained) @(negedge CLK);
      cfg_width  = DIMB'(w);
      cfg_height = DIMB'(h);
      start      = 1'b1;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b1 || done !== 1'b0) begin
         errors++;
         $display("FAIL %s start_accept: busy=%b in_ready=%b done=%b, want 1 1 0",
                  name, busy, in_ready, done);
      end
      idx = 0; got = 0; cyc = 0; last_hs = -10; stall_left = 0;
      done_seen = 0; stall_used = 0; prev_stalled = 0; prev_data = '0;
      budget = 30 * n + 100;
      while (!done_seen && cyc < budget) begin
         if (stall_n > 0 && !stall_used && out_valid === 1'b1) begin
            stall_used = 1;
            stall_left = stall_n;
         end
         if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
         end else begin
            out_ready = ($urandom_range(99) < rpct);
         end
         in_valid = (idx < n) && ($urandom_range(99) < vpct);
         in_data  = (idx < n) ? pix_q[idx] : rand_pix();
         start    = mid_start && (cyc == 3);
         cfg_width = mid_start ? DIMB'(3) : DIMB'(w);
         #1;
         if (prev_stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin
               errors++;
               $display("FAIL %s hold_output: valid=%b data=%h, want 1 %h",
                        name, out_valid, out_data, prev_data);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b0) begin
            checks++;
            if (in_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s stall_in_ready: in_ready=%b, want 0", name, in_ready);
            end
         end
         prev_stalled = (out_valid === 1'b1) && !out_ready;
         prev_data    = out_data;
         checks++;
         if (cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL %s no_cfg_err: cfg_err=%b, want 0", name, cfg_err);
         end
         if (done === 1'b1) begin
            done_seen = 1;
            checks++;
            if (cyc != last_hs + 1 || got != exp_q.size()) begin
               errors++;
               $display("FAIL %s done_timing: done at cycle %0d outputs %0d, want cycle %0d outputs %0d",
                        name, cyc, got, last_hs + 1, exp_q.size());
            end
            checks++;
            if (busy !== 1'b0) begin
               errors++;
               $display("FAIL %s busy_with_done: busy=%b, want 0", name, busy);
            end
         end else begin
            if (out_valid === 1'b1 && out_ready) begin
               checks++;
               if (got >= exp_q.size()) begin
                  errors++;
                  $display("FAIL %s extra_output: data=%h, want none", name, out_data);
               end else if (out_data !== exp_q[got]) begin
                  errors++;
                  $display("FAIL %s out_data[%0d]: got %h, want %h", name, got, out_data, exp_q[got]);
               end else begin
                  last_out = out_data;
               end
               got++;
               last_hs = cyc;
            end
            if (in_valid && in_ready === 1'b1) idx++;
            checks++;
            if (busy !== 1'b1) begin
               errors++;
               $display("FAIL %s busy_mid_frame: busy=%b, want 1", name, busy);
            end
            @(negedge CLK);
            cyc++;
         end
      end
      start = 1'b0;
      in_valid = 1'b0;
      checks++;
      if (!done_seen) begin
         errors++;
         $display("FAIL %s timeout: no done after %0d cycles, want done", name, cyc);
      end
      checks++;
      if (idx != n || got != exp_q.size()) begin
         errors++;
         $display("FAIL %s counts: pixels %0d outputs %0d, want %0d %0d",
                  name, idx, got, n, exp_q.size());
      end
      if (!chained) begin
         @(negedge CLK);
         #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_pulse: done=%b busy=%b, want 0 0", name, done, busy);
         end
      end
   endtask

   task automatic load_pix(input logic [DW-1:0] a[]);
      pix_q.delete();
      foreach (a[i]) pix_q.push_back(a[i]);
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
          busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_values: rdy=%b ov=%b od=%h busy=%b done=%b err=%b, want all 0",
                  in_ready, out_valid, out_data, busy, done, cfg_err);
      end
      repeat (3) @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      load_pix('{64'd1, 64'd5, 64'd3, 64'd2, 64'd4, 64'd0, 64'd7, 64'd9});
      run_frame(4, 2, 100, 100, 0, 0, 0, "basic");
      checks++;
      if (last_out !== 64'd9) begin
         errors++;
         $display("FAIL basic_last: got %h, want 9", last_out);
      end
   endtask

   task automatic test_backpressure();
      load_pix('{64'd1, 64'd5, 64'd3, 64'd2, 64'd4, 64'd0, 64'd7, 64'd9});
      run_frame(4, 2, 100, 100, 5, 0, 0, "backpressure");
   endtask

   task automatic test_cfg_err();
      int bad_w[2];
      bad_w[0] = 3;
      bad_w[1] = MAXW + 2;
      for (int i = 0; i < 2; i++) begin
         @(negedge CLK);
         cfg_width  = DIMB'(bad_w[i]);
         cfg_height = DIMB'(2);
         start      = 1'b1;
         out_ready  = 1'b1;
         @(negedge CLK);
         start = 1'b0;
         #1;
         checks++;
         if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_w%0d: err=%b busy=%b rdy=%b, want 1 0 0",
                     bad_w[i], cfg_err, busy, in_ready);
         end
         @(negedge CLK);
         #1;
         checks++;
         if (cfg_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse_w%0d: err=%b busy=%b, want 0 0", bad_w[i], cfg_err, busy);
         end
      end
   endtask

   task automatic test_start_mid_frame();
      load_pix('{64'd1, 64'd5, 64'd3, 64'd2, 64'd4, 64'd0, 64'd7, 64'd9});
      run_frame(4, 2, 100, 100, 0, 1, 0, "mid_start");
   endtask

   task automatic test_reset_mid_frame();
      @(negedge CLK);
      cfg_width  = DIMB'(4);
      cfg_height = DIMB'(2);
      start      = 1'b1;
      out_ready  = 1'b1;
      @(negedge CLK);
      start    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = DW'(i + 100);
         @(negedge CLK);
      end
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #1;
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 ||
          busy !== 1'b0 || done !== 1'b0 || cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_frame: rdy=%b ov=%b od=%h busy=%b done=%b err=%b, want all 0",
                  in_ready, out_valid, out_data, busy, done, cfg_err);
      end
      @(negedge CLK);
      rst_n = 1'b1;
      load_pix('{64'd10, 64'd20, 64'd30, 64'd40});
      run_frame(2, 2, 100, 100, 0, 0, 0, "after_reset");
      checks++;
      if (last_out !== 64'd40) begin
         errors++;
         $display("FAIL after_reset_value: got %h, want 40", last_out);
      end
   endtask

   task automatic test_signed();
      logic [DW-1:0] want;
      load_pix('{64'd1, -64'sd5, 64'd3, 64'd2});
`ifdef MAXPOOL_CTRL_SIGNED_EN
      want = 64'd3;
`else
      want = 64'hFFFF_FFFF_FFFF_FFFB;
`endif
      run_frame(2, 2, 100, 100, 0, 0, 0, "sign_mix");
      checks++;
      if (last_out !== want) begin
         errors++;
         $display("FAIL sign_mix_value: got %h, want %h", last_out, want);
      end
      load_pix('{-64'sd1, -64'sd5, -64'sd3, -64'sd2});
      run_frame(2, 2, 100, 100, 0, 0, 0, "all_negative");
      checks++;
      if (last_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin
         errors++;
         $display("FAIL all_negative_value: got %h, want ffffffffffffffff", last_out);
      end
   endtask

   task automatic test_random();
      int w, h;
      for (int f = 0; f < 8; f++) begin
         w = 2 * $urandom_range(1, 8);
         h = 2 * $urandom_range(1, 3);
         pix_q.delete();
         for (int i = 0; i < w * h; i++) pix_q.push_back(rand_pix());
         run_frame(w, h, $urandom_range(40, 100), $urandom_range(30, 100), 0, 0, 0, "random");
      end
      w = MAXW;
      pix_q.delete();
      for (int i = 0; i < w * 2; i++) pix_q.push_back(rand_pix());
      run_frame(w, 2, 90, 80, 0, 0, 0, "max_width");
   endtask

   task automatic test_back_to_back();
      pix_q.delete();
      for (int i = 0; i < 16; i++) pix_q.push_back(rand_pix());
      run_frame(8, 2, 100, 100, 0, 0, 1, "b2b_first");
      run_frame(8, 2, 100, 100, 0, 0, 1, "b2b_second");
      pix_q.delete();
      for (int i = 0; i < 8; i++) pix_q.push_back(rand_pix());
      run_frame(4, 2, 100, 70, 0, 0, 0, "b2b_third");
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      cfg_width  = '0;
      cfg_height = '0;
      in_valid   = 1'b0;
      in_data    = '0;
      out_ready  = 1'b0;
      last_out   = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_cfg_err();
      test_start_mid_frame();
      test_reset_mid_frame();
      test_signed();
      test_random();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/maxpool_ctrl.md
# maxpool_ctrl

Streaming 2x2 / stride-2 max-pool controller for one feature-map plane. Accepts pixels in raster order over a valid/ready stream, keeps half a row of horizontal pair maxima in a line buffer, and emits one pooled pixel per 2x2 window on an output valid/ready stream. Sits between the conv output stream and the next layer's input, sequencing the pool datapath per frame under a start/done handshake.

## Interface
- DATAWIDTH, 64, pixel width in bits
- MAX_W, 256, maximum frame width in pixels (even)
- DIM_BITS, 9, width of dimension and counter fields ($clog2(MAX_W)+1)
- CLK  input  1  clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle frame start request, sampled in IDLE only
- cfg_width  input  DIM_BITS  frame width in pixels, sampled on start
- cfg_height  input  DIM_BITS  frame height in rows, sampled on start
- in_valid  input  1  input pixel valid
- in_ready  output  1  controller accepts pixel this cycle
- in_data  input  DATAWIDTH  input pixel
- out_valid  output  1  pooled pixel valid
- out_ready  input  1  downstream accepts pooled pixel
- out_data  output  DATAWIDTH  pooled pixel
- busy  output  1  frame in progress
- done  output  1  one-cycle pulse, frame complete
- cfg_err  output  1  one-cycle pulse, start rejected

## Operation
- States: IDLE, RUN, FLUSH.
- IDLE: on start, check config: width and height nonzero, both even, width <= MAX_W. Valid -> latch dims, clear col/row counters, go RUN. Invalid -> pulse cfg_err next cycle, stay IDLE.
- RUN: a pixel is accepted on in_valid && in_ready. in_ready = 1 in RUN when !out_valid || out_ready.
- Even row, even col: h_reg <= pixel. Even row, odd col: linebuf[col>>1] <= max(h_reg, pixel).
- Odd row, even col: h_reg <= pixel. Odd row, odd col: out_data <= max(linebuf[col>>1], max(h_reg, pixel)); out_valid <= 1.
- col increments per accepted pixel, wraps to 0 at width-1 and increments row.
- Last pixel (row height-1, col width-1) accepted -> FLUSH.
- FLUSH: in_ready = 0; when out_valid && out_ready (or out_valid already 0) -> pulse done, go IDLE.
- out_valid clears on out_ready unless a new result is loaded the same cycle (then stays 1 with new data).
- Comparisons unsigned by default; ties select either operand (equal value).
- busy = 1 in RUN and FLUSH.
- start while busy: ignored, no cfg_err.
- Reset (any state): all state cleared, go IDLE, pending output discarded; line buffer contents need not be cleared.

## Timing
- Reset values: in_ready 0, out_valid 0, out_data 0, busy 0, done 0, cfg_err 0.
- start accepted at edge N -> busy and in_ready high from N+1.
- Output latency: pooled pixel on out_valid one cycle after the window's last pixel (odd row, odd col) handshake.
- Throughput: one pixel per cycle without backpressure; pooled output rate W/2 per odd row.
- done asserted exactly one cycle, in the cycle after the final output handshake; busy falls the same cycle done rises.
- cfg_err asserted the cycle after the rejected start.
- Back-to-back frames: start may be asserted the cycle done is high (IDLE), accepted normally.

## Configuration
- MAXPOOL_CTRL_SIGNED_EN defined: all max comparisons treat pixels as two's-complement signed DATAWIDTH values.
- Undefined: unsigned comparisons. Interface and timing identical in both builds.

## Structure
- Shared package maxpool_pkg: DATAWIDTH default, MAX_W default, state enum (IDLE, RUN, FLUSH), max2 compare function honoring MAXPOOL_CTRL_SIGNED_EN.
- Sub-module maxpool_line_buf: MAX_W/2 x DATAWIDTH register array, one synchronous write port, one combinational read port, no reset on storage.
- Counters, FSM, h_reg, output register in maxpool_ctrl.

## Test plan
- 4x2 frame, row0 = 1,5,3,2; row1 = 4,0,7,9; out_ready=1 -> outputs 5 then 9, done one cycle after second handshake.
- Same frame with out_ready held 0 for 5 cycles after first output -> in_ready drops, out_data stays 5, no pixel lost, outputs 5,9 in order.
- start with cfg_width=3 (odd), and with cfg_width=MAX_W+2 -> cfg_err pulse, busy stays 0, in_ready stays 0.
- start pulsed mid-frame -> ignored; frame completes with correct results, single done.
- rst_n asserted mid-frame after 3 pixels -> all outputs 0 immediately; new 2x2 frame 10,20,30,40 after reset -> output 40.
- SIGNED_EN build, 2x2 frame -1,-5,-3,-2 (two's complement) -> output -1; unsigned build same data -> output 0xFF..FF (-1 bit pattern is max also; check with 1,-5,3,2 -> signed 3, unsigned -5 pattern).
